// File: rtl/memoria_pkg.sv
// Shared types and width defaults for the data-memory arbiter.
package memoria_pkg;

    localparam int BITS_PALAVRA_PADRAO  = 16;
    localparam int BITS_ENDERECO_PADRAO = 16;

    typedef enum logic [1:0] {
        OCIOSO,
        EMITE,
        AGUARDA,
        CONCLUI
    } estado_t;

    typedef logic porta_t;

endpackage

// File: rtl/arbitro_rr2.sv
// Combinational two-way round-robin picker: on a tie the port not granted last wins.
module arbitro_rr2
    import memoria_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic ultimo,
    output logic valido,
    output logic vencedor
);

    porta_t escolha;

    always_comb begin
        escolha = 1'b0;
        if (req0 && req1) begin
            escolha = ~ultimo;
        end else if (req1) begin
            escolha = 1'b1;
        end
    end

    assign valido   = req0 | req1;
    assign vencedor = escolha;

endmodule

// File: rtl/arbitro_memoria_dados.sv
// Round-robin arbiter/sequencer giving two ports one-at-a-time access to the 16-bit data memory.
module arbitro_memoria_dados
    import memoria_pkg::*;
#(
    parameter int BITS_PALAVRA  = BITS_PALAVRA_PADRAO,
    parameter int BITS_ENDERECO = BITS_ENDERECO_PADRAO
)
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req0,
    input  logic                     we0,
    input  logic [BITS_ENDERECO-1:0] addr0,
    input  logic [BITS_PALAVRA-1:0]  wdata0,
    output logic                     ack0,
    output logic [BITS_PALAVRA-1:0]  rdata0,
    input  logic                     req1,
    input  logic                     we1,
    input  logic [BITS_ENDERECO-1:0] addr1,
    input  logic [BITS_PALAVRA-1:0]  wdata1,
    output logic                     ack1,
    output logic [BITS_PALAVRA-1:0]  rdata1,
    output logic                     mem_hab_escrita,
    output logic [BITS_ENDERECO-1:0] mem_endereco,
    output logic [BITS_PALAVRA-1:0]  mem_entrada,
    input  logic [BITS_PALAVRA-1:0]  mem_saida,
    output logic                     ocupado,
    output logic                     concedido
);

    estado_t estado, prox;
    porta_t  ultimo, lat_porta, vencedor;
    logic    lat_we, valido;

    arbitro_rr2 u_arbitro (
        .req0     (req0),
        .req1     (req1),
        .ultimo   (ultimo),
        .valido   (valido),
        .vencedor (vencedor)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox;
        end
    end

    always_comb begin
        prox = estado;
        case (estado)
            OCIOSO:  if (valido) prox = EMITE;
            EMITE:   prox = AGUARDA;
            AGUARDA: prox = CONCLUI;
            CONCLUI: prox = OCIOSO;
            default: prox = OCIOSO;
        endcase
    end

    // Requests are only looked at in OCIOSO; the latch alone drives the memory afterwards.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ultimo       <= 1'b1;
            lat_porta    <= 1'b0;
            lat_we       <= 1'b0;
            mem_endereco <= '0;
            mem_entrada  <= '0;
        end else if (estado == OCIOSO && valido) begin
            ultimo       <= vencedor;
            lat_porta    <= vencedor;
            lat_we       <= vencedor ? we1 : we0;
            mem_endereco <= vencedor ? addr1 : addr0;
            mem_entrada  <= vencedor ? wdata1 : wdata0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else if (estado == AGUARDA) begin
            if (lat_porta) begin
                rdata1 <= mem_saida;
            end else begin
                rdata0 <= mem_saida;
            end
        end
    end

    // Reset gates the write strobe and acks so an aborted access never reaches memory.
    always_comb begin
        mem_hab_escrita = reset && (estado == EMITE) && lat_we;
        ack0            = reset && (estado == CONCLUI) && !lat_porta;
        ack1            = reset && (estado == CONCLUI) && lat_porta;
        ocupado         = (estado != OCIOSO);
    end

    assign concedido = lat_porta;

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// Directed bench for arbitro_memoria_dados with a behavioural read-on-write-edge memory.
module tb_arbitro_memoria_dados;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [15:0] addr0, wdata0, addr1, wdata1;
    logic        ack0, ack1;
    logic [15:0] rdata0, rdata1;
    logic        mem_hab_escrita;
    logic [15:0] mem_endereco, mem_entrada;
    logic [15:0] mem_saida = 16'h0;
    logic        ocupado, concedido;

    logic [15:0] memoria [0:65535];

    int n_comparados = 0;
    int n_divergentes = 0;

    always #5 clock = ~clock;

    arbitro_memoria_dados dut (
        .clock           (clock),
        .reset           (reset),
        .req0            (req0),
        .we0             (we0),
        .addr0           (addr0),
        .wdata0          (wdata0),
        .ack0            (ack0),
        .rdata0          (rdata0),
        .req1            (req1),
        .we1             (we1),
        .addr1           (addr1),
        .wdata1          (wdata1),
        .ack1            (ack1),
        .rdata1          (rdata1),
        .mem_hab_escrita (mem_hab_escrita),
        .mem_endereco    (mem_endereco),
        .mem_entrada     (mem_entrada),
        .mem_saida       (mem_saida),
        .ocupado         (ocupado),
        .concedido       (concedido)
    );

    always @(posedge clock) begin
        if (mem_hab_escrita) begin
            memoria[mem_endereco] <= mem_entrada;
            mem_saida             <= mem_entrada;
        end else begin
            mem_saida <= memoria[mem_endereco];
        end
    end

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_comparados++;
        if (obs !== esp) begin
            n_divergentes++;
            $display("FAIL %s: observado=%0h esperado=%0h", tag, obs, esp);
        end
    endtask

    task automatic espera_ocioso();
        int n = 0;
        @(negedge clock);
        while (ocupado && n < 10) begin
            @(negedge clock);
            n++;
        end
        if (ocupado) verifica("timeout_ocioso", 32'(ocupado), 32'h0);
    endtask

    task automatic acesso(input string tag, input int porta, input logic we,
                          input logic [15:0] a, input logic [15:0] d, output logic [15:0] dado);
        int   ciclos = 0;
        logic outro  = 1'b0;
        espera_ocioso();
        if (porta == 0) begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            ciclos++;
            if (porta == 0 ? ack1 : ack0) outro = 1'b1;
            if (porta == 0 ? ack0 : ack1) break;
        end
        dado = (porta == 0) ? rdata0 : rdata1;
        if (porta == 0) req0 = 1'b0; else req1 = 1'b0;
        verifica({tag, "_latencia"}, 32'(ciclos), 32'd3);
        verifica({tag, "_outro_ack"}, 32'(outro), 32'h0);
    endtask

    initial begin
        logic [15:0] dado, r0, r1;
        int t0, t1, n_ev, n_ack1;
        int ev_porta [3];
        int ev_ciclo [3];
        logic escrita_vista, ack_visto;

        reset = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0033; wdata0 = 16'h7777;
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0044; wdata1 = 16'h8888;

        // Reset held with both ports requesting writes.
        escrita_vista = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            if (mem_hab_escrita) escrita_vista = 1'b1;
            verifica("reset_ctrl", 32'({ack0, ack1, mem_hab_escrita, ocupado, concedido}), 32'h0);
        end
        verifica("reset_escrita", 32'(escrita_vista), 32'h0);
        verifica("reset_endereco", 32'(mem_endereco), 32'h0);
        verifica("reset_entrada", 32'(mem_entrada), 32'h0);
        verifica("reset_rdata", 32'({rdata0, rdata1}), 32'h0);
        @(negedge clock);
        req0 = 1'b0; req1 = 1'b0;
        reset = 1'b1;

        // Tie straight after reset: port 0 first, port 1 four cycles later.
        espera_ocioso();
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0001; wdata0 = 16'h1111;
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0002; wdata1 = 16'h2222;
        t0 = 0; t1 = 0; r0 = '0; r1 = '0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clock); #1;
            if (ack0 && t0 == 0) begin t0 = c; r0 = rdata0; req0 = 1'b0; end
            if (ack1 && t1 == 0) begin t1 = c; r1 = rdata1; req1 = 1'b0; end
            if (t0 != 0 && t1 != 0) break;
        end
        req0 = 1'b0; req1 = 1'b0;
        verifica("empate_t0", 32'(t0), 32'd3);
        verifica("empate_t1", 32'(t1), 32'd7);
        verifica("empate_r0", 32'(r0), 32'h1111);
        verifica("empate_r1", 32'(r1), 32'h2222);
        acesso("le_0001", 0, 1'b0, 16'h0001, 16'h0, dado);
        verifica("le_0001_dado", 32'(dado), 32'h1111);
        acesso("le_0002", 1, 1'b0, 16'h0002, 16'h0, dado);
        verifica("le_0002_dado", 32'(dado), 32'h2222);

        // Single write then read on port 0.
        acesso("esc_beef", 0, 1'b1, 16'h0010, 16'hBEEF, dado);
        verifica("esc_beef_dado", 32'(dado), 32'hBEEF);
        acesso("le_beef", 0, 1'b0, 16'h0010, 16'h0, dado);
        verifica("le_beef_dado", 32'(dado), 32'hBEEF);

        // Fairness: port 1 holds req, port 0 joins during port 1's EMITE.
        espera_ocioso();
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0002;
        n_ev = 0; n_ack1 = 0;
        for (int i = 0; i < 3; i++) begin ev_porta[i] = -1; ev_ciclo[i] = 0; end
        r0 = '0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clock); #1;
            if (c == 1) begin
                verifica("justica_emite", 32'({ocupado, concedido}), 32'h3);
                req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0001;
            end
            if (ack0 && n_ev < 3) begin
                ev_porta[n_ev] = 0; ev_ciclo[n_ev] = c; n_ev++;
                r0 = rdata0; req0 = 1'b0;
            end
            if (ack1 && n_ev < 3) begin
                ev_porta[n_ev] = 1; ev_ciclo[n_ev] = c; n_ev++;
                n_ack1++;
                if (n_ack1 == 2) req1 = 1'b0;
            end
            if (n_ev == 3) break;
        end
        req0 = 1'b0; req1 = 1'b0;
        verifica("justica_ordem", 32'({ev_porta[0][1:0], ev_porta[1][1:0], ev_porta[2][1:0]}), 32'b01_00_01);
        verifica("justica_ciclo1", 32'(ev_ciclo[1]), 32'd7);
        verifica("justica_ciclo2", 32'(ev_ciclo[2]), 32'd11);
        verifica("justica_r0", 32'(r0), 32'h1111);

        // Reset during EMITE of a port 1 write must abort it.
        acesso("prev_0100", 1, 1'b1, 16'h0100, 16'h1234, dado);
        espera_ocioso();
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0100; wdata1 = 16'hDEAD;
        @(posedge clock); #1;
        verifica("aborto_emite", 32'({ocupado, concedido}), 32'h3);
        reset = 1'b0;
        #1;
        verifica("aborto_hab_escrita", 32'(mem_hab_escrita), 32'h0);
        req1 = 1'b0;
        @(posedge clock); #1;
        verifica("aborto_ocupado", 32'(ocupado), 32'h0);
        reset = 1'b1;
        ack_visto = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock); #1;
            if (ack1 || ack0) ack_visto = 1'b1;
        end
        verifica("aborto_sem_ack", 32'(ack_visto), 32'h0);
        acesso("aborto_le", 1, 1'b0, 16'h0100, 16'h0, dado);
        verifica("aborto_le_dado", 32'(dado), 32'h1234);

        // Top address is an ordinary location.
        acesso("esc_0000", 0, 1'b1, 16'h0000, 16'h5A5A, dado);
        acesso("esc_ffff", 1, 1'b1, 16'hFFFF, 16'hA5A5, dado);
        verifica("esc_ffff_dado", 32'(dado), 32'hA5A5);
        verifica("esc_ffff_concedido", 32'(concedido), 32'h1);
        acesso("le_ffff", 1, 1'b0, 16'hFFFF, 16'h0, dado);
        verifica("le_ffff_dado", 32'(dado), 32'hA5A5);
        acesso("le_0000", 1, 1'b0, 16'h0000, 16'h0, dado);
        verifica("le_0000_dado", 32'(dado), 32'h5A5A);
        verifica("rdata0_mantido", 32'(rdata0), 32'h5A5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comparados, n_divergentes);
        $finish;
    end

endmodule

// File: doc/arbitro_memoria_dados.md
# arbitro_memoria_dados

Two-port round-robin arbiter and sequencer for the 16-bit data memory. Port 0 is the processor load/store path and port 1 is the loader/DMA path. The block grants one requester at a time, drives the memory's write-enable, address and data inputs for exactly one access, and returns the read data with a one-cycle acknowledge. It sits between the datapath and the data memory; the memory is reachable only through this block.

## Interface
Parameters:
- BITS_PALAVRA, 16, data word width
- BITS_ENDERECO, 16, address width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- req0  in  1  port 0 request; held high until ack0
- we0  in  1  port 0 write (1) / read (0); stable while req0 is high
- addr0  in  BITS_ENDERECO  port 0 address
- wdata0  in  BITS_PALAVRA  port 0 write data
- ack0  out  1  one-cycle completion pulse for port 0
- rdata0  out  BITS_PALAVRA  port 0 read data; valid when ack0 is high
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1
- mem_hab_escrita  out  1  memory write enable
- mem_endereco  out  BITS_ENDERECO  memory address
- mem_entrada  out  BITS_PALAVRA  memory write data
- mem_saida  in  BITS_PALAVRA  memory output; registered by the memory on the same edge as the write
- ocupado  out  1  high in every state except OCIOSO
- concedido  out  1  index of the granted or last-granted port

## Operation
- FSM states: OCIOSO, EMITE, AGUARDA, CONCLUI.
- OCIOSO:
  - Any req high: latch the winner's index, we, addr and wdata, then go to EMITE.
  - Otherwise stay in OCIOSO.
- EMITE:
  - mem_hab_escrita = latched we AND reset.
  - mem_endereco and mem_entrada come from the latch.
  - Go to AGUARDA.
- AGUARDA: mem_hab_escrita = 0; address and data held. Capture mem_saida into the granted port's rdata register. Go to CONCLUI.
- CONCLUI: ack of the granted port = 1 and the other ack = 0. Go to OCIOSO.
- Arbitration, evaluated only in OCIOSO:
  - A single requester wins.
  - When both request, the winner is the port not recorded in `ultimo`. `ultimo` is updated on every grant.
  - `ultimo` resets to 1, so port 0 wins the first tie.
- Writes: rdata returns the value just written, because the memory reads back on the write edge.
- Requests that change while not in OCIOSO are ignored. The latch is the only source for memory signals.
- A requester that still holds req in the CONCLUI cycle presents a new request. Requesters must drop req on the cycle after ack.
- Address 0xFFFF (the top address) is a legal access with no special handling. There is no address arithmetic and no wrap.
- rdata0 and rdata1 hold their last captured value until that port's next AGUARDA.

## Timing
- Reset (reset = 0 at a rising edge):
  - State returns to OCIOSO; `ultimo` = 1.
  - ack0, ack1, mem_hab_escrita, ocupado and concedido are 0.
  - mem_endereco, mem_entrada, rdata0 and rdata1 are 0.
- Reset mid-operation: any in-flight access is aborted and no ack is issued.
- Reset during EMITE: mem_hab_escrita is gated combinationally by reset, so no write reaches memory.
- Latency: req sampled in OCIOSO at edge E, then EMITE in cycle E+1, AGUARDA in E+2, CONCLUI (ack) in E+3.
- Throughput: one access every 4 cycles; back-to-back accesses have no idle gap beyond the OCIOSO cycle.
- Simultaneous req0 and req1: served in alternating order, 4 cycles apart. Worst-case wait for a port is 8 cycles from req to ack.
- ack and mem_hab_escrita are state decodes (AND reset) and are glitch-free at the clock edge. All other outputs are registered.

## Structure
- Package `memoria_pkg`:
  - estado_t enum (OCIOSO, EMITE, AGUARDA, CONCLUI)
  - BITS_PALAVRA and BITS_ENDERECO defaults
  - porta_t (1-bit port index)
- Sub-module `arbitro_rr2`: combinational 2-way round-robin picker. Inputs are req0, req1 and ultimo; outputs are valido and vencedor. The FSM, latch and rdata registers stay in the top module.

## Test plan
- Reset: hold reset = 0 for 3 cycles with req0 = req1 = 1 → all outputs 0, no ack, ocupado = 0, mem_hab_escrita never 1.
- Single write then read: port 0 writes 0xBEEF to 0x0010, then reads 0x0010 → ack0 exactly 3 cycles after each sample; write rdata0 = 0xBEEF; read rdata0 = 0xBEEF; ack1 stays 0.
- Tie: req0 and req1 rise together (port 0 writes 0x1111 to 0x0001, port 1 writes 0x2222 to 0x0002) → port 0 acked at E+3, port 1 at E+7; readback returns 0x1111 and 0x2222.
- Fairness: port 1 requests continuously; port 0 raises req during port 1's EMITE → next grant goes to port 0, so no port gets two consecutive grants while the other waits.
- Abort: reset = 0 during EMITE of a port 1 write of 0xDEAD to 0x0100 → no ack1, and a later read of 0x0100 returns the prior value.
- Boundary: port 1 writes 0xA5A5 to 0xFFFF and reads it back → rdata1 = 0xA5A5; address 0x0000 is unaffected.
